distribute_1x2_seq: RTL and testbench
=====================================

# distribute_1x2_seq

Registered 1-to-2 distributor: the split-direction counterpart of the 2x1 merge. It takes one valid-qualified data word and steers it to either of two output lanes, to both, or alternately between them, under `i_cmd`. It sits at fan-out points of the NoC, such as a root feeding two subtrees or a distribution tree level, with one cycle of latency per stage. Outputs carry dummy data `{DATA_WIDTH{1'b0}}` whenever a lane is not valid.

## Interface
- `DATA_WIDTH`, 32: width of one data word.
- `COMMAND_WIDTH`, 2: width of the routing command.
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `i_valid`  input  1: input word valid.
- `i_data_bus`  input  DATA_WIDTH: input word.
- `i_en`  input  1: block enable.
- `i_cmd`  input  COMMAND_WIDTH: routing command, sampled with `i_valid`.
- `o_valid`  output  2: lane valids; bit 0 is the low lane, bit 1 is the high lane.
- `o_data_bus`  output  2*DATA_WIDTH: lane 0 on `[DATA_WIDTH-1:0]`, lane 1 on `[2*DATA_WIDTH-1:DATA_WIDTH]`.

## Operation
- Accepted beat: `i_en & i_valid` is high at a rising edge.
- Command decode for an accepted beat:
  - `2'b00`: lane 0 only.
  - `2'b01`: lane 1 only.
  - `2'b10`: broadcast; both lanes carry the same word.
  - `2'b11`: round-robin; the beat goes to the lane selected by internal pointer `rr_ptr` (1 bit).
- `rr_ptr`:
  - Toggles only on an accepted beat with `i_cmd==2'b11`.
  - Holds on every other cycle, including beats with other commands and disabled cycles.
  - Resets to 0, so the first round-robin beat goes to lane 0.
- Lanes not selected in a cycle: `o_valid` bit is 0 and the data slice is all zeros.
- No accepted beat (`i_en=0` or `i_valid=0`): both lanes are invalid with zero data the next cycle. No data is held or replayed.
- The block has no backpressure. Downstream must consume every valid beat in the cycle it appears.

## Timing
- Latency is exactly 1 cycle. A beat accepted at edge N appears on the outputs from edge N to edge N+1.
- Full throughput: one beat per cycle, back-to-back, with any mix of commands.
- Reset values (outputs): `o_valid=2'b00`, `o_data_bus=0`. Internal `rr_ptr=0`.
- Reset priority:
  - Reset mid-stream wins over a simultaneous accepted beat: the beat is dropped and the outputs are zero on the following cycle.
  - The first beat after reset deassertion is accepted normally.
- `i_en` deasserted mid-stream: the outputs go invalid one cycle later and `rr_ptr` is preserved. Reasserting `i_en` resumes the alternation where it left off.
- Simultaneous events: a round-robin beat in the same cycle as `rr_ptr` toggling uses the pre-toggle value.
- The outputs are pure registers, with no combinational path from inputs to outputs.

## Configuration
- Macro: `DISTRIBUTE_1X2_BROADCAST_EN`.
- Defined: `i_cmd=2'b10` broadcasts to both lanes, as described above.
- Undefined:
  - The broadcast path is not built.
  - `i_cmd=2'b10` drops the beat: `o_valid=2'b00`, data zero, `rr_ptr` unchanged.
  - All other commands behave identically.

## Test plan
- Reset behaviour: hold `rst=1` for 3 cycles with `i_en=1`, `i_valid=1`, `i_cmd=2'b10`, data `32'hAAAAAAAA`. Required: `o_valid=2'b00` and `o_data_bus=0` throughout; the first beat after release appears 1 cycle later.
- Directed routing: `i_en=1`, then beats `32'h11111111` with cmd `00` and `32'h22222222` with cmd `01` on consecutive cycles. Required: `o_valid=01` with low lane `32'h11111111` and high lane 0, then `o_valid=10` with high lane `32'h22222222` and low lane 0.
- Broadcast: cmd `10`, data `32'h5A5A5A5A`. Required with the macro defined: `o_valid=11` and `o_data_bus=64'h5A5A5A5A5A5A5A5A`. Required without it: `o_valid=00` and data 0.
- Round-robin with a gap:
  - Stimulus: four cmd `11` beats with data 1, 2, 3, 4, with an `i_en=0` cycle between the 2nd and 3rd beat.
  - Required lanes: 0, 1, 0, 1, plus one all-invalid cycle at the gap.
- Disable: `i_en=0`, `i_valid=1`, cmd `00`, data `32'hAAAAAAAA`. Required: `o_valid=00` and data 0.
- Mid-stream reset: after one cmd `11` beat (`rr_ptr=1`), assert `rst` for 1 cycle, then send a cmd `11` beat. Required: that beat lands on lane 0.

Source files
------------

// File: rtl/distribute_1x2_seq.sv
// Registered 1-to-2 distributor: steers one valid-qualified word to lane 0, lane 1, both, or round-robin.
// Latency: exactly 1 cycle, full throughput (one beat per cycle, any command mix).
// Backpressure: none; downstream must take every valid beat in the cycle it appears.
//
// Ports:
//   clk, rst            - single rising-edge clock, synchronous active-high reset
//   i_valid, i_data_bus - input word and its qualifier
//   i_en                - block enable; a beat is accepted when i_en & i_valid
//   i_cmd               - routing command: 00 lane 0, 01 lane 1, 10 broadcast, 11 round-robin
//   o_valid             - per-lane valid, bit 0 = low lane, bit 1 = high lane
//   o_data_bus          - lane 0 on the low DATA_WIDTH bits, lane 1 on the high bits
//
// Build option: define DISTRIBUTE_1X2_BROADCAST_EN to build the broadcast path.
// Without it, cmd 10 drops the beat (no lane valid, round-robin pointer untouched).

module distribute_1x2_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_data_bus,
  input  logic                      i_en,
  input  logic [COMMAND_WIDTH-1:0]  i_cmd,
  output logic [1:0]                o_valid,
  output logic [2*DATA_WIDTH-1:0]   o_data_bus
);

  localparam logic [COMMAND_WIDTH-1:0] CMD_LANE0 = COMMAND_WIDTH'(2'b00);
  localparam logic [COMMAND_WIDTH-1:0] CMD_LANE1 = COMMAND_WIDTH'(2'b01);
  localparam logic [COMMAND_WIDTH-1:0] CMD_BCAST = COMMAND_WIDTH'(2'b10);
  localparam logic [COMMAND_WIDTH-1:0] CMD_RR    = COMMAND_WIDTH'(2'b11);

  logic            beat_acc;
  logic [1:0]      lane_sel;
  logic            rr_toggle;
  logic            rr_ptr;
  logic [DATA_WIDTH-1:0] lane0_nxt;
  logic [DATA_WIDTH-1:0] lane1_nxt;

  assign beat_acc = i_en & i_valid;

  // Lane select for the current beat. Round-robin reads the pointer before
  // it toggles, so the first round-robin beat after reset goes to lane 0.
  always_comb begin
    lane_sel  = 2'b00;
    rr_toggle = 1'b0;
    if (beat_acc) begin
      case (i_cmd)
        CMD_LANE0: lane_sel = 2'b01;
        CMD_LANE1: lane_sel = 2'b10;
        CMD_BCAST: begin
`ifdef DISTRIBUTE_1X2_BROADCAST_EN
          lane_sel = 2'b11;
`else
          lane_sel = 2'b00;
`endif
        end
        CMD_RR: begin
          lane_sel  = rr_ptr ? 2'b10 : 2'b01;
          rr_toggle = 1'b1;
        end
        // Wider command encodings beyond the four defined ones drop the beat.
        default: lane_sel = 2'b00;
      endcase
    end
  end

  // Unselected lanes carry zeros rather than a stale or passthrough word.
  assign lane0_nxt = lane_sel[0] ? i_data_bus : {DATA_WIDTH{1'b0}};
  assign lane1_nxt = lane_sel[1] ? i_data_bus : {DATA_WIDTH{1'b0}};

  // Outputs are pure registers; reset takes priority over a same-cycle beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 2'b00;
      o_data_bus <= {(2*DATA_WIDTH){1'b0}};
      rr_ptr     <= 1'b0;
    end else begin
      o_valid    <= lane_sel;
      o_data_bus <= {lane1_nxt, lane0_nxt};
      if (rr_toggle) begin
        rr_ptr <= ~rr_ptr;
      end
    end
  end

endmodule

// File: tb/tb_distribute_1x2_seq.sv
// Directed self-checking bench for distribute_1x2_seq.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants per scenario.

module tb_distribute_1x2_seq;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_data_bus;
  logic        i_en;
  logic [1:0]  i_cmd;
  logic [1:0]  o_valid;
  logic [63:0] o_data_bus;

  int n_cmp;
  int n_fail;

  distribute_1x2_seq #(
    .DATA_WIDTH    (32),
    .COMMAND_WIDTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of inputs for one cycle, then move to the sample point.
  task automatic cycle(input logic r, input logic en, input logic v,
                       input logic [1:0] cmd, input logic [31:0] d);
    @(negedge clk);
    rst        = r;
    i_en       = en;
    i_valid    = v;
    i_cmd      = cmd;
    i_data_bus = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 2'b10, 32'hAAAAAAAA);
      n_cmp++;
      if (o_valid !== 2'b00 || o_data_bus !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: valid=%b data=%h, want valid=00 data=0", i, o_valid, o_data_bus);
      end
    end
    cycle(1'b0, 1'b1, 1'b1, 2'b00, 32'h12345678);
    n_cmp++;
    if (o_valid !== 2'b01 || o_data_bus !== 64'h00000000_12345678) begin
      n_fail++;
      $display("FAIL reset_first_beat: valid=%b data=%h, want valid=01 data=0000000012345678", o_valid, o_data_bus);
    end
  endtask

  task automatic test_directed;
    cycle(1'b0, 1'b1, 1'b1, 2'b00, 32'h11111111);
    n_cmp++;
    if (o_valid !== 2'b01 || o_data_bus !== 64'h00000000_11111111) begin
      n_fail++;
      $display("FAIL directed_lane0: valid=%b data=%h, want valid=01 data=0000000011111111", o_valid, o_data_bus);
    end
    cycle(1'b0, 1'b1, 1'b1, 2'b01, 32'h22222222);
    n_cmp++;
    if (o_valid !== 2'b10 || o_data_bus !== 64'h22222222_00000000) begin
      n_fail++;
      $display("FAIL directed_lane1: valid=%b data=%h, want valid=10 data=2222222200000000", o_valid, o_data_bus);
    end
    // Enabled but not valid: nothing accepted, no replay of the last word.
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'h33333333);
    n_cmp++;
    if (o_valid !== 2'b00 || o_data_bus !== 64'h0) begin
      n_fail++;
      $display("FAIL directed_novalid: valid=%b data=%h, want valid=00 data=0", o_valid, o_data_bus);
    end
  endtask

  task automatic test_broadcast;
    logic [1:0]  exp_v;
    logic [63:0] exp_d;
`ifdef DISTRIBUTE_1X2_BROADCAST_EN
    exp_v = 2'b11;
    exp_d = 64'h5A5A5A5A_5A5A5A5A;
`else
    exp_v = 2'b00;
    exp_d = 64'h0;
`endif
    cycle(1'b0, 1'b1, 1'b1, 2'b10, 32'h5A5A5A5A);
    n_cmp++;
    if (o_valid !== exp_v || o_data_bus !== exp_d) begin
      n_fail++;
      $display("FAIL broadcast: valid=%b data=%h, want valid=%b data=%h", o_valid, o_data_bus, exp_v, exp_d);
    end
  endtask

  // Pointer is still 0 here: no round-robin beat since reset, broadcast never touches it.
  task automatic test_round_robin;
    logic [1:0]  exp_v [5];
    logic [63:0] exp_d [5];
    logic        en_seq [5];
    logic [31:0] d_seq [5];
    en_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    d_seq  = '{32'd1, 32'd2, 32'h99, 32'd3, 32'd4};
    exp_v  = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    exp_d  = '{64'h00000000_00000001, 64'h00000002_00000000, 64'h0,
               64'h00000000_00000003, 64'h00000004_00000000};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, en_seq[i], 1'b1, 2'b11, d_seq[i]);
      n_cmp++;
      if (o_valid !== exp_v[i] || o_data_bus !== exp_d[i]) begin
        n_fail++;
        $display("FAIL rr_gap[%0d]: valid=%b data=%h, want valid=%b data=%h",
                 i, o_valid, o_data_bus, exp_v[i], exp_d[i]);
      end
    end
  endtask

  // Other commands must not advance the pointer (now back at 0).
  task automatic test_rr_hold;
    cycle(1'b0, 1'b1, 1'b1, 2'b11, 32'hA0000001);
    n_cmp++;
    if (o_valid !== 2'b01 || o_data_bus !== 64'h00000000_A0000001) begin
      n_fail++;
      $display("FAIL rr_hold_first: valid=%b data=%h, want valid=01 data=00000000a0000001", o_valid, o_data_bus);
    end
    cycle(1'b0, 1'b1, 1'b1, 2'b00, 32'hB0000002);
    n_cmp++;
    if (o_valid !== 2'b01 || o_data_bus !== 64'h00000000_B0000002) begin
      n_fail++;
      $display("FAIL rr_hold_other: valid=%b data=%h, want valid=01 data=00000000b0000002", o_valid, o_data_bus);
    end
    cycle(1'b0, 1'b1, 1'b0, 2'b11, 32'hDEADBEEF);
    n_cmp++;
    if (o_valid !== 2'b00 || o_data_bus !== 64'h0) begin
      n_fail++;
      $display("FAIL rr_hold_idle: valid=%b data=%h, want valid=00 data=0", o_valid, o_data_bus);
    end
    cycle(1'b0, 1'b1, 1'b1, 2'b11, 32'hC0000003);
    n_cmp++;
    if (o_valid !== 2'b10 || o_data_bus !== 64'hC0000003_00000000) begin
      n_fail++;
      $display("FAIL rr_hold_second: valid=%b data=%h, want valid=10 data=c000000300000000", o_valid, o_data_bus);
    end
  endtask

  task automatic test_disable;
    cycle(1'b0, 1'b0, 1'b1, 2'b00, 32'hAAAAAAAA);
    n_cmp++;
    if (o_valid !== 2'b00 || o_data_bus !== 64'h0) begin
      n_fail++;
      $display("FAIL disable: valid=%b data=%h, want valid=00 data=0", o_valid, o_data_bus);
    end
  endtask

  // Pointer is 0 on entry; one rr beat sets it to 1, reset must clear it.
  task automatic test_midstream_reset;
    cycle(1'b0, 1'b1, 1'b1, 2'b11, 32'h0000AAAA);
    n_cmp++;
    if (o_valid !== 2'b01 || o_data_bus !== 64'h00000000_0000AAAA) begin
      n_fail++;
      $display("FAIL mid_rst_pre: valid=%b data=%h, want valid=01 data=000000000000aaaa", o_valid, o_data_bus);
    end
    cycle(1'b1, 1'b1, 1'b1, 2'b11, 32'h0000BBBB);
    n_cmp++;
    if (o_valid !== 2'b00 || o_data_bus !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_rst_drop: valid=%b data=%h, want valid=00 data=0", o_valid, o_data_bus);
    end
    cycle(1'b0, 1'b1, 1'b1, 2'b11, 32'h0000CAFE);
    n_cmp++;
    if (o_valid !== 2'b01 || o_data_bus !== 64'h00000000_0000CAFE) begin
      n_fail++;
      $display("FAIL mid_rst_post: valid=%b data=%h, want valid=01 data=000000000000cafe", o_valid, o_data_bus);
    end
  endtask

  task automatic test_back_to_back;
    cycle(1'b0, 1'b1, 1'b1, 2'b01, 32'h01010101);
    n_cmp++;
    if (o_valid !== 2'b10 || o_data_bus !== 64'h01010101_00000000) begin
      n_fail++;
      $display("FAIL b2b_lane1: valid=%b data=%h, want valid=10 data=0101010100000000", o_valid, o_data_bus);
    end
    cycle(1'b0, 1'b1, 1'b1, 2'b11, 32'h02020202);
    n_cmp++;
    if (o_valid !== 2'b10 || o_data_bus !== 64'h02020202_00000000) begin
      n_fail++;
      $display("FAIL b2b_rr: valid=%b data=%h, want valid=10 data=0202020200000000", o_valid, o_data_bus);
    end
    cycle(1'b0, 1'b1, 1'b1, 2'b00, 32'h03030303);
    n_cmp++;
    if (o_valid !== 2'b01 || o_data_bus !== 64'h00000000_03030303) begin
      n_fail++;
      $display("FAIL b2b_lane0: valid=%b data=%h, want valid=01 data=0000000003030303", o_valid, o_data_bus);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    i_en       = 1'b0;
    i_valid    = 1'b0;
    i_cmd      = 2'b00;
    i_data_bus = 32'h0;
    test_reset();
    test_directed();
    test_broadcast();
    test_round_robin();
    test_rr_hold();
    test_disable();
    test_midstream_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
